enigma_seq_ctrl: RTL and testbench

Sequencer that sits in front of the three-rotor Enigma datapath (rotor stack plus UKW-B reflector). It accepts rotor start positions and plaintext characters over valid/ready handshakes, drives `load_config`, `step_enable` and `char_in` in the Enigma order: step first, then encipher. It captures `char_out` into a registered output stream, so the combinational datapath never faces a downstream stall.

---
 rtl/enigma_pkg.sv | 23 ++
 rtl/enigma_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_enigma_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared types for the Enigma sequencer and datapath.
// Holds the alphabet size, the 5-bit character type and the sequencer states.
// Types only; carries no timing or flow-control behaviour of its own.
package enigma_pkg;

  localparam int ALPHA_SIZE = 26;

  typedef logic [4:0] char_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_ENC,
    S_HOLD
  } seq_state_t;

  // True for codes the rotor stack can encipher (A..Z as 0..25).
  function automatic logic is_letter(input char_t c);
    return (c < 5'(ALPHA_SIZE));
  endfunction

endpackage

// File: rtl/enigma_seq_ctrl.sv
// Sequencer in front of the three-rotor Enigma datapath: step the rotors, then encipher.
// Latency 3 cycles from character accept to out_valid; at most one character per 4 cycles.
// Accepts input only in IDLE; a stalled output is held in HOLD until out_ready.
module enigma_seq_ctrl
  import enigma_pkg::*;
#(
  parameter bit PASS_INVALID = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [4:0]       i_cfg_pos_r1,
  input  logic [4:0]       i_cfg_pos_r2,
  input  logic [4:0]       i_cfg_pos_r3,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [4:0]       i_in_char,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [4:0]       o_out_char,
  output logic             o_load_config,
  output logic             o_step_enable,
  output logic [4:0]       o_init_pos_r1,
  output logic [4:0]       o_init_pos_r2,
  output logic [4:0]       o_init_pos_r3,
  output logic [4:0]       o_char_in,
  input  logic [4:0]       i_char_out,
  output logic [CNT_W-1:0] o_char_count,
  output logic             o_err_pulse
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             w_cfg_take;
  logic             w_char_take;
  logic             w_pass;
  logic             w_drop;
  logic             w_enc;
  logic             w_pop;

  char_t            r_char;
  char_t            r_char_in;
  char_t            r_out_char;
  logic             r_out_valid;
  logic [4:0]       r_pos_r1;
  logic [4:0]       r_pos_r2;
  logic [4:0]       r_pos_r3;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  // State register; reset aborts any in-flight character.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, handshake readies and single-cycle datapath strobes.
  // Readies depend only on the registered state (plus config priority), never on out_ready.
  always_comb begin
    w_state_nxt   = r_state;
    o_cfg_ready   = 1'b0;
    o_in_ready    = 1'b0;
    o_load_config = 1'b0;
    o_step_enable = 1'b0;
    w_cfg_take    = 1'b0;
    w_char_take   = 1'b0;
    w_pass        = 1'b0;
    w_drop        = 1'b0;
    w_enc         = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cfg_ready = 1'b1;
        o_in_ready  = !i_cfg_valid;
        if (i_cfg_valid) begin
          w_cfg_take  = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (i_in_valid) begin
          if (is_letter(i_in_char)) begin
            w_char_take = 1'b1;
            w_state_nxt = S_STEP;
          end else if (PASS_INVALID) begin
            w_pass      = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_drop      = 1'b1;
          end
        end
      end
      S_LOAD: begin
        o_load_config = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_STEP: begin
        o_step_enable = 1'b1;
        w_state_nxt   = S_ENC;
      end
      S_ENC: begin
        w_enc       = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_out_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config/character capture, output register and enciphered-character counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_char      <= '0;
      r_char_in   <= '0;
      r_out_char  <= '0;
      r_out_valid <= 1'b0;
      r_pos_r1    <= '0;
      r_pos_r2    <= '0;
      r_pos_r3    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_drop;
      if (w_cfg_take) begin
        r_pos_r1 <= i_cfg_pos_r1;
        r_pos_r2 <= i_cfg_pos_r2;
        r_pos_r3 <= i_cfg_pos_r3;
      end
      if (w_char_take) r_char <= i_in_char;
      // Present the character to the rotors only after they have stepped.
      if (r_state == S_STEP) r_char_in <= r_char;
      if (r_state == S_LOAD) r_count <= '0;
      if (w_pass) begin
        r_out_char  <= i_in_char;
        r_out_valid <= 1'b1;
      end
      if (w_enc) begin
        r_out_char  <= i_char_out;
        r_out_valid <= 1'b1;
        r_count     <= r_count + CNT_W'(1);
      end
      if (w_pop) r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_char    = r_out_char;
  assign o_char_in     = r_char_in;
  assign o_init_pos_r1 = r_pos_r1;
  assign o_init_pos_r2 = r_pos_r2;
  assign o_init_pos_r3 = r_pos_r3;
  assign o_char_count  = r_count;
  assign o_err_pulse   = r_err;

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Bench for enigma_seq_ctrl: directed timing checks plus randomized traffic.
// A toy rotor (char + pos1 mod 26) stands in for the datapath behind each instance.
// Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
module tb_enigma_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: invalid codes pass through.
  logic        cfg_valid = 0, cfg_ready;
  logic [4:0]  p1 = 0, p2 = 0, p3 = 0;
  logic        in_valid = 0, in_ready;
  logic [4:0]  in_char = 0;
  logic        out_valid, out_ready = 1;
  logic [4:0]  out_char;
  logic        load_config, step_enable;
  logic [4:0]  ip1, ip2, ip3, char_in, char_out;
  logic [15:0] char_count;
  logic        err_pulse;

  // Instance B: invalid codes are dropped with an error pulse.
  logic        cfg_ready_b;
  logic        in_valid_b = 0, in_ready_b;
  logic [4:0]  in_char_b = 0;
  logic        out_valid_b;
  logic [4:0]  out_char_b;
  logic        load_config_b, step_enable_b;
  logic [4:0]  ip1_b, ip2_b, ip3_b, char_in_b, char_out_b;
  logic [15:0] char_count_b;
  logic        err_pulse_b;

  enigma_seq_ctrl #(.PASS_INVALID(1'b1), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_pos_r1(p1), .i_cfg_pos_r2(p2), .i_cfg_pos_r3(p3),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_char(in_char),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_char(out_char),
    .o_load_config(load_config), .o_step_enable(step_enable),
    .o_init_pos_r1(ip1), .o_init_pos_r2(ip2), .o_init_pos_r3(ip3),
    .o_char_in(char_in), .i_char_out(char_out),
    .o_char_count(char_count), .o_err_pulse(err_pulse)
  );

  enigma_seq_ctrl #(.PASS_INVALID(1'b0), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_cfg_valid(1'b0), .o_cfg_ready(cfg_ready_b),
    .i_cfg_pos_r1(5'd0), .i_cfg_pos_r2(5'd0), .i_cfg_pos_r3(5'd0),
    .i_in_valid(in_valid_b), .o_in_ready(in_ready_b), .i_in_char(in_char_b),
    .o_out_valid(out_valid_b), .i_out_ready(1'b1), .o_out_char(out_char_b),
    .o_load_config(load_config_b), .o_step_enable(step_enable_b),
    .o_init_pos_r1(ip1_b), .o_init_pos_r2(ip2_b), .o_init_pos_r3(ip3_b),
    .o_char_in(char_in_b), .i_char_out(char_out_b),
    .o_char_count(char_count_b), .o_err_pulse(err_pulse_b)
  );

  // Toy datapath models: first rotor position only.
  logic [4:0] dp_pos, dp_pos_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_pos   <= '0;
      dp_pos_b <= '0;
    end else begin
      if (load_config)      dp_pos <= ip1;
      else if (step_enable) dp_pos <= (dp_pos == 5'd25) ? 5'd0 : dp_pos + 5'd1;
      if (load_config_b)      dp_pos_b <= ip1_b;
      else if (step_enable_b) dp_pos_b <= (dp_pos_b == 5'd25) ? 5'd0 : dp_pos_b + 5'd1;
    end
  end
  assign char_out   = 5'((int'(char_in) + int'(dp_pos)) % 26);
  assign char_out_b = 5'((int'(char_in_b) + int'(dp_pos_b)) % 26);

  // Reference model state: rotor position, count and pending ciphertext.
  int n_vec = 0;
  int n_bad = 0;
  int mpos  = 0;
  int mcnt  = 0;
  int expq[$];
  bit rnd_rdy = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: account for handshakes about to complete, then advance.
  task automatic cyc();
    chk_eq("step_load_excl", 32'(step_enable && load_config), 32'd0);
    if (cfg_valid && cfg_ready) begin
      mpos = int'(p1);
      mcnt = 0;
    end else if (in_valid && in_ready) begin
      if (in_char < 5'd26) begin
        mpos = (mpos + 1) % 26;
        mcnt = (mcnt + 1) % 65536;
        expq.push_back((int'(in_char) + mpos) % 26);
      end else begin
        expq.push_back(int'(in_char));
      end
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk_eq("spurious_out", 32'(out_char), 32'hFFFF_FFFF);
      else                  chk_eq("sb_out_char", 32'(out_char), 32'(expq.pop_front()));
      chk_eq("sb_char_count", 32'(char_count), 32'(mcnt));
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_char(input logic [4:0] c);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!acc && n < 100) begin
      acc = in_ready;
      cyc();
      n++;
    end
    if (!acc) chk_eq("in_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bit acc = 0;
    int n = 0;
    cfg_valid = 1'b1;
    p1 = a; p2 = b; p3 = c;
    while (!acc && n < 100) begin
      acc = cfg_ready;
      cyc();
      n++;
    end
    if (!acc) chk_eq("cfg_accept_timeout", 32'd0, 32'd1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset values.
    #12;
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_char_count", 32'(char_count), 32'd0);
    chk_eq("rst_out_char", 32'(out_char), 32'd0);
    chk_eq("rst_char_in", 32'(char_in), 32'd0);
    chk_eq("rst_init_pos", 32'({ip1, ip2, ip3}), 32'd0);
    chk_eq("rst_strobes", 32'({load_config, step_enable, err_pulse}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Config (3,0,0): one-cycle load pulse.
    cfg_valid = 1'b1; p1 = 5'd3; p2 = 5'd0; p3 = 5'd0;
    cyc();
    cfg_valid = 1'b0;
    chk_eq("cfg_load_hi", 32'(load_config), 32'd1);
    chk_eq("cfg_pos_r1", 32'(ip1), 32'd3);
    chk_eq("cfg_ready_lo", 32'(cfg_ready), 32'd0);
    cyc();
    chk_eq("cfg_load_lo", 32'(load_config), 32'd0);
    chk_eq("cfg_count", 32'(char_count), 32'd0);
    chk_eq("cfg_in_ready", 32'(in_ready), 32'd1);

    // Char 7: step at N+1, char_in at N+2, output 11 at N+3.
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = 5'd7;
    cyc();
    in_valid = 1'b0;
    chk_eq("c7_step_n1", 32'(step_enable), 32'd1);
    chk_eq("c7_ovld_n1", 32'(out_valid), 32'd0);
    cyc();
    chk_eq("c7_step_n2", 32'(step_enable), 32'd0);
    chk_eq("c7_char_in", 32'(char_in), 32'd7);
    chk_eq("c7_ovld_n2", 32'(out_valid), 32'd0);
    cyc();
    chk_eq("c7_ovld_n3", 32'(out_valid), 32'd1);
    chk_eq("c7_out_char", 32'(out_char), 32'd11);
    chk_eq("c7_count", 32'(char_count), 32'd1);
    cyc();
    chk_eq("c7_ovld_done", 32'(out_valid), 32'd0);

    // Config and char together: config wins, char taken two cycles later.
    cfg_valid = 1'b1; p1 = 5'd5; p2 = 5'd1; p3 = 5'd2;
    in_valid = 1'b1; in_char = 5'd2;
    #1;
    chk_eq("both_in_ready", 32'(in_ready), 32'd0);
    chk_eq("both_cfg_ready", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0;
    chk_eq("both_load", 32'(load_config), 32'd1);
    chk_eq("both_in_ready_load", 32'(in_ready), 32'd0);
    cyc();
    chk_eq("both_in_ready_idle", 32'(in_ready), 32'd1);
    chk_eq("both_count_clr", 32'(char_count), 32'd0);
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk_eq("both_step", 32'(step_enable), 32'd1);
    cyc();
    cyc();
    // Stall for 5 cycles: (2 + 6) mod 26 held.
    for (int i = 0; i < 5; i++) begin
      chk_eq("stall_ovld", 32'(out_valid), 32'd1);
      chk_eq("stall_out_char", 32'(out_char), 32'd8);
      chk_eq("stall_in_ready", 32'(in_ready), 32'd0);
      chk_eq("stall_step", 32'(step_enable), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk_eq("stall_release", 32'(out_valid), 32'd0);

    // Code 30 bypasses: no step, count unchanged.
    in_valid = 1'b1; in_char = 5'd30;
    cyc();
    in_valid = 1'b0;
    chk_eq("pass_ovld", 32'(out_valid), 32'd1);
    chk_eq("pass_out_char", 32'(out_char), 32'd30);
    chk_eq("pass_step", 32'(step_enable), 32'd0);
    chk_eq("pass_count", 32'(char_count), 32'd1);
    cyc();
    chk_eq("pass_done", 32'(out_valid), 32'd0);

    // Drop mode on instance B: error pulse, no output; then a letter from position 0.
    in_valid_b = 1'b1; in_char_b = 5'd30;
    cyc();
    in_valid_b = 1'b0;
    chk_eq("drop_err_hi", 32'(err_pulse_b), 32'd1);
    chk_eq("drop_ovld", 32'(out_valid_b), 32'd0);
    chk_eq("drop_step", 32'(step_enable_b), 32'd0);
    cyc();
    chk_eq("drop_err_lo", 32'(err_pulse_b), 32'd0);
    chk_eq("drop_in_ready", 32'(in_ready_b), 32'd1);
    in_valid_b = 1'b1; in_char_b = 5'd4;
    cyc();
    in_valid_b = 1'b0;
    cyc();
    cyc();
    chk_eq("b_ovld", 32'(out_valid_b), 32'd1);
    chk_eq("b_out_char", 32'(out_char_b), 32'd5);
    chk_eq("b_count", 32'(char_count_b), 32'd1);
    cyc();
    chk_eq("b_done", 32'(out_valid_b), 32'd0);

    // Reset asserted while in ENC.
    in_valid = 1'b1; in_char = 5'd10;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk_eq("arst_ovld", 32'(out_valid), 32'd0);
    chk_eq("arst_count", 32'(char_count), 32'd0);
    chk_eq("arst_char_in", 32'(char_in), 32'd0);
    expq.delete();
    mpos = 0;
    mcnt = 0;
    #2;
    rst_n = 1'b1;
    cyc();
    chk_eq("arst_in_ready", 32'(in_ready), 32'd1);
    chk_eq("arst_idle_ovld", 32'(out_valid), 32'd0);
    chk_eq("arst_idle_step", 32'(step_enable), 32'd0);

    // Randomized traffic checked by the scoreboard in cyc().
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        send_cfg(5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)));
      else if ($urandom_range(0, 3) == 0)
        send_char(5'($urandom_range(26, 31)));
      else
        send_char(5'($urandom_range(0, 25)));
      for (int j = $urandom_range(0, 2); j > 0; j--) cyc();
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    chk_eq("drain_empty", 32'(expq.size()), 32'd0);
    chk_eq("drain_ovld", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
